serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_pkg.sv | 12 +
 rtl/fa_slice.sv | 15 +
 rtl/serial_add_ctrl.sv | 112 +++++++++++
 tb/tb_serial_add_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding and width limit.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/fa_slice.sv
// One-bit combinational full adder; the only arithmetic in the serial adder.
module fa_slice (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   always_comb begin
      sum  = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one fa_slice stepped LSB-first over WIDTH bits.
// Optional subtract (sub port, b inverted with carry-in forced to 1) under SERIAL_ADD_SUB_EN.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("serial_add_ctrl: WIDTH out of range 1..32");
   end

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             s_bit;
   logic             c_bit;
   logic [WIDTH-1:0] b_load;
   logic             c_load;

   fa_slice u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .sum  (s_bit),
      .cout (c_bit)
   );

`ifdef SERIAL_ADD_SUB_EN
   always_comb begin
      b_load = sub ? ~b : b;
      c_load = sub ? 1'b1 : cin;
   end
`else
   always_comb begin
      b_load = b;
      c_load = cin;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         a_sr  <= '0;
         b_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b_load;
                  carry <= c_load;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               // shift-in at MSB written as a shift/or so WIDTH=1 needs no special slice
               sum   <= (sum >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               carry <= c_bit;
               if (cnt == LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  cout  <= c_bit;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8); subtract vectors run only with SERIAL_ADD_SUB_EN.
module tb_serial_add_ctrl;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   typedef struct {
      string        name;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one operation and check busy/done timing and the result cycle by cycle.
   task automatic run_op(input vec_t v);
      @(negedge clk);
      a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= int'(W); k++) begin
         chk({v.name, " busy"}, 32'(busy), 32'd1);
         chk({v.name, " done early"}, 32'(done), 32'd0);
         @(negedge clk);
      end
      chk({v.name, " done"}, 32'(done), 32'd1);
      chk({v.name, " busy at done"}, 32'(busy), 32'd0);
      chk({v.name, " sum"}, 32'(sum), 32'(v.exp_sum));
      chk({v.name, " cout"}, 32'(cout), 32'(v.exp_cout));
      @(negedge clk);
      chk({v.name, " done pulse"}, 32'(done), 32'd0);
      chk({v.name, " sum hold"}, 32'(sum), 32'(v.exp_sum));
   endtask

   initial begin
      vecs[0] = '{"5a+3c",     8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0};
      vecs[1] = '{"ff+01",     8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{"ff+ff+1",   8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
      vecs[3] = '{"00+00+1",   8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0};
      vecs[4] = '{"80+80",     8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[5] = '{"12+34+1",   8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0};
      vecs[6] = '{"aa+55",     8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0};
      vecs[7] = '{"7f+01",     8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0};
      vecs[8] = '{"10-01",     8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1};
      vecs[9] = '{"00-01 cin", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0};

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset sum", 32'(sum), 32'd0);
      chk("reset cout", 32'(cout), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
`ifdef SERIAL_ADD_SUB_EN
         run_op(vecs[i]);
`else
         if (!vecs[i].sub) run_op(vecs[i]);
`endif
      end

      // start pulses at T+3 and T+9 must be ignored
      @(negedge clk);
      a = 8'h5A; b = 8'h3C; cin = 1'b0; sub = 1'b0; start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         start = (c == 3 || c == 9);
         chk($sformatf("ign busy c%0d", c), 32'(busy), 32'((c >= 1 && c <= 8) ? 1 : 0));
         chk($sformatf("ign done c%0d", c), 32'(done), 32'((c == 9) ? 1 : 0));
         if (c == 4) begin a = 8'h01; b = 8'h01; end
         if (c >= 9) chk($sformatf("ign sum c%0d", c), 32'(sum), 32'h96);
      end
      start = 1'b0;

      // reset mid-RUN at T+4
      @(negedge clk);
      a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst sum", 32'(sum), 32'd0);
      chk("midrst cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk($sformatf("postrst done c%0d", c), 32'(done), 32'd0);
         chk($sformatf("postrst busy c%0d", c), 32'(busy), 32'd0);
      end
      run_op(vecs[0]);

      // start held high: one operation every W+2 cycles
      @(negedge clk);
      a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b0; start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         chk($sformatf("hold done c%0d", c), 32'(done), 32'((c % 10 == 9) ? 1 : 0));
         chk($sformatf("hold busy c%0d", c), 32'(busy), 32'((c % 10 >= 1 && c % 10 <= 8) ? 1 : 0));
         if (c % 10 == 9) begin
            chk($sformatf("hold sum c%0d", c), 32'(sum), 32'hFF);
            chk($sformatf("hold cout c%0d", c), 32'(cout), 32'd1);
         end
         if (c == 30) start = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("hold stop busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
